// File: rtl/axi4_router_1x2.sv
// axi4_router_1x2: one AXI4 master fanned out to two slaves by address window, one active slave per direction.
module axi4_router_1x2 #(
  parameter int unsigned AXI4_ADDRESS_WIDTH = 32,
  parameter int unsigned AXI4_DATA_WIDTH = 32,
  parameter int unsigned AXI4_ID_WIDTH = 4,
  parameter logic [AXI4_ADDRESS_WIDTH-1:0] S0_BASE = 32'h0000_0000,
  parameter logic [AXI4_ADDRESS_WIDTH-1:0] S0_LIMIT = 32'h0FFF_FFFF,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic clk_i,
  input  logic rst_n,
  input  logic [AXI4_ID_WIDTH-1:0] in_awid,
  input  logic [AXI4_ADDRESS_WIDTH-1:0] in_awaddr,
  input  logic [7:0] in_awlen,
  input  logic [2:0] in_awsize,
  input  logic [1:0] in_awburst,
  input  logic in_awlock,
  input  logic [3:0] in_awcache,
  input  logic [2:0] in_awprot,
  input  logic [3:0] in_awqos,
  input  logic [3:0] in_awregion,
  input  logic in_awvalid,
  output logic in_awready,
  input  logic [AXI4_DATA_WIDTH-1:0] in_wdata,
  input  logic [AXI4_DATA_WIDTH/8-1:0] in_wstrb,
  input  logic in_wlast,
  input  logic in_wvalid,
  output logic in_wready,
  output logic [AXI4_ID_WIDTH-1:0] in_bid,
  output logic [1:0] in_bresp,
  output logic in_bvalid,
  input  logic in_bready,
  input  logic [AXI4_ID_WIDTH-1:0] in_arid,
  input  logic [AXI4_ADDRESS_WIDTH-1:0] in_araddr,
  input  logic [7:0] in_arlen,
  input  logic [2:0] in_arsize,
  input  logic [1:0] in_arburst,
  input  logic in_arlock,
  input  logic [3:0] in_arcache,
  input  logic [2:0] in_arprot,
  input  logic [3:0] in_arqos,
  input  logic [3:0] in_arregion,
  input  logic in_arvalid,
  output logic in_arready,
  output logic [AXI4_ID_WIDTH-1:0] in_rid,
  output logic [AXI4_DATA_WIDTH-1:0] in_rdata,
  output logic [1:0] in_rresp,
  output logic in_rlast,
  output logic in_rvalid,
  input  logic in_rready,
  output logic [AXI4_ID_WIDTH-1:0] s0_awid,
  output logic [AXI4_ADDRESS_WIDTH-1:0] s0_awaddr,
  output logic [7:0] s0_awlen,
  output logic [2:0] s0_awsize,
  output logic [1:0] s0_awburst,
  output logic s0_awlock,
  output logic [3:0] s0_awcache,
  output logic [2:0] s0_awprot,
  output logic [3:0] s0_awqos,
  output logic [3:0] s0_awregion,
  output logic s0_awvalid,
  input  logic s0_awready,
  output logic [AXI4_DATA_WIDTH-1:0] s0_wdata,
  output logic [AXI4_DATA_WIDTH/8-1:0] s0_wstrb,
  output logic s0_wlast,
  output logic s0_wvalid,
  input  logic s0_wready,
  input  logic [AXI4_ID_WIDTH-1:0] s0_bid,
  input  logic [1:0] s0_bresp,
  input  logic s0_bvalid,
  output logic s0_bready,
  output logic [AXI4_ID_WIDTH-1:0] s0_arid,
  output logic [AXI4_ADDRESS_WIDTH-1:0] s0_araddr,
  output logic [7:0] s0_arlen,
  output logic [2:0] s0_arsize,
  output logic [1:0] s0_arburst,
  output logic s0_arlock,
  output logic [3:0] s0_arcache,
  output logic [2:0] s0_arprot,
  output logic [3:0] s0_arqos,
  output logic [3:0] s0_arregion,
  output logic s0_arvalid,
  input  logic s0_arready,
  input  logic [AXI4_ID_WIDTH-1:0] s0_rid,
  input  logic [AXI4_DATA_WIDTH-1:0] s0_rdata,
  input  logic [1:0] s0_rresp,
  input  logic s0_rlast,
  input  logic s0_rvalid,
  output logic s0_rready,
  output logic [AXI4_ID_WIDTH-1:0] s1_awid,
  output logic [AXI4_ADDRESS_WIDTH-1:0] s1_awaddr,
  output logic [7:0] s1_awlen,
  output logic [2:0] s1_awsize,
  output logic [1:0] s1_awburst,
  output logic s1_awlock,
  output logic [3:0] s1_awcache,
  output logic [2:0] s1_awprot,
  output logic [3:0] s1_awqos,
  output logic [3:0] s1_awregion,
  output logic s1_awvalid,
  input  logic s1_awready,
  output logic [AXI4_DATA_WIDTH-1:0] s1_wdata,
  output logic [AXI4_DATA_WIDTH/8-1:0] s1_wstrb,
  output logic s1_wlast,
  output logic s1_wvalid,
  input  logic s1_wready,
  input  logic [AXI4_ID_WIDTH-1:0] s1_bid,
  input  logic [1:0] s1_bresp,
  input  logic s1_bvalid,
  output logic s1_bready,
  output logic [AXI4_ID_WIDTH-1:0] s1_arid,
  output logic [AXI4_ADDRESS_WIDTH-1:0] s1_araddr,
  output logic [7:0] s1_arlen,
  output logic [2:0] s1_arsize,
  output logic [1:0] s1_arburst,
  output logic s1_arlock,
  output logic [3:0] s1_arcache,
  output logic [2:0] s1_arprot,
  output logic [3:0] s1_arqos,
  output logic [3:0] s1_arregion,
  output logic s1_arvalid,
  input  logic s1_arready,
  input  logic [AXI4_ID_WIDTH-1:0] s1_rid,
  input  logic [AXI4_DATA_WIDTH-1:0] s1_rdata,
  input  logic [1:0] s1_rresp,
  input  logic s1_rlast,
  input  logic s1_rvalid,
  output logic s1_rready
);
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PW = $clog2(MAX_OUTSTANDING);
  localparam logic [CW-1:0] CMAX = CW'(MAX_OUTSTANDING);
  logic [CW-1:0] wr_cnt, rd_cnt;
  logic wr_tgt, rd_tgt;
  logic [PW:0] wp, rp;
  logic fifo_q [MAX_OUTSTANDING];
  logic aw_sel, ar_sel, aw_ok, ar_ok, w_full, w_empty, w_head, w_act, w_pop, b_act, r_act, b_hs, r_done;
  // Offset compare keeps the window check a single unsigned test even when S0_BASE is zero.
  function automatic logic to_s1(input logic [AXI4_ADDRESS_WIDTH-1:0] a);
    return (a - S0_BASE) > (S0_LIMIT - S0_BASE);
  endfunction
  assign s0_awid = in_awid;         assign s1_awid = in_awid;
  assign s0_awaddr = in_awaddr;     assign s1_awaddr = in_awaddr;
  assign s0_awlen = in_awlen;       assign s1_awlen = in_awlen;
  assign s0_awsize = in_awsize;     assign s1_awsize = in_awsize;
  assign s0_awburst = in_awburst;   assign s1_awburst = in_awburst;
  assign s0_awlock = in_awlock;     assign s1_awlock = in_awlock;
  assign s0_awcache = in_awcache;   assign s1_awcache = in_awcache;
  assign s0_awprot = in_awprot;     assign s1_awprot = in_awprot;
  assign s0_awqos = in_awqos;       assign s1_awqos = in_awqos;
  assign s0_awregion = in_awregion; assign s1_awregion = in_awregion;
  assign s0_wdata = in_wdata;       assign s1_wdata = in_wdata;
  assign s0_wstrb = in_wstrb;       assign s1_wstrb = in_wstrb;
  assign s0_wlast = in_wlast;       assign s1_wlast = in_wlast;
  assign s0_arid = in_arid;         assign s1_arid = in_arid;
  assign s0_araddr = in_araddr;     assign s1_araddr = in_araddr;
  assign s0_arlen = in_arlen;       assign s1_arlen = in_arlen;
  assign s0_arsize = in_arsize;     assign s1_arsize = in_arsize;
  assign s0_arburst = in_arburst;   assign s1_arburst = in_arburst;
  assign s0_arlock = in_arlock;     assign s1_arlock = in_arlock;
  assign s0_arcache = in_arcache;   assign s1_arcache = in_arcache;
  assign s0_arprot = in_arprot;     assign s1_arprot = in_arprot;
  assign s0_arqos = in_arqos;       assign s1_arqos = in_arqos;
  assign s0_arregion = in_arregion; assign s1_arregion = in_arregion;
  assign aw_sel = to_s1(in_awaddr);
  assign ar_sel = to_s1(in_araddr);
  assign w_empty = wp == rp;
  assign w_full = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
  assign w_head = fifo_q[rp[PW-1:0]];
  // Every handshake term carries rst_n so all VALID/READY drop the moment reset asserts.
  assign aw_ok = rst_n && in_awvalid && wr_cnt != CMAX && !w_full && (wr_cnt == '0 || aw_sel == wr_tgt);
  assign ar_ok = rst_n && in_arvalid && rd_cnt != CMAX && (rd_cnt == '0 || ar_sel == rd_tgt);
  assign w_act = rst_n && !w_empty;
  assign b_act = rst_n && wr_cnt != '0;
  assign r_act = rst_n && rd_cnt != '0;
  assign s0_awvalid = aw_ok && !aw_sel;
  assign s1_awvalid = aw_ok && aw_sel;
  assign in_awready = aw_ok && (aw_sel ? s1_awready : s0_awready);
  assign s0_wvalid = w_act && !w_head && in_wvalid;
  assign s1_wvalid = w_act && w_head && in_wvalid;
  assign in_wready = w_act && (w_head ? s1_wready : s0_wready);
  assign w_pop = in_wvalid && in_wready && in_wlast;
  assign in_bvalid = b_act && (wr_tgt ? s1_bvalid : s0_bvalid);
  assign in_bid = wr_tgt ? s1_bid : s0_bid;
  assign in_bresp = wr_tgt ? s1_bresp : s0_bresp;
  assign s0_bready = b_act && !wr_tgt && in_bready;
  assign s1_bready = b_act && wr_tgt && in_bready;
  assign b_hs = in_bvalid && in_bready;
  assign s0_arvalid = ar_ok && !ar_sel;
  assign s1_arvalid = ar_ok && ar_sel;
  assign in_arready = ar_ok && (ar_sel ? s1_arready : s0_arready);
  assign in_rvalid = r_act && (rd_tgt ? s1_rvalid : s0_rvalid);
  assign in_rid = rd_tgt ? s1_rid : s0_rid;
  assign in_rdata = rd_tgt ? s1_rdata : s0_rdata;
  assign in_rresp = rd_tgt ? s1_rresp : s0_rresp;
  assign in_rlast = rd_tgt ? s1_rlast : s0_rlast;
  assign s0_rready = r_act && !rd_tgt && in_rready;
  assign s1_rready = r_act && rd_tgt && in_rready;
  assign r_done = in_rvalid && in_rready && in_rlast;
  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
      wr_tgt <= 1'b0;
      rd_tgt <= 1'b0;
      wp <= '0;
      rp <= '0;
    end else begin
      wr_cnt <= wr_cnt + CW'(in_awready) - CW'(b_hs);
      rd_cnt <= rd_cnt + CW'(in_arready) - CW'(r_done);
      if (in_awready) wr_tgt <= aw_sel;
      if (in_arready) rd_tgt <= ar_sel;
      wp <= wp + (PW+1)'(in_awready);
      rp <= rp + (PW+1)'(w_pop);
    end
  // Route FIFO entries are only read between push and pop, so they need no reset.
  always_ff @(posedge clk_i)
    if (in_awready) fifo_q[wp[PW-1:0]] <= aw_sel;
endmodule

// File: tb/tb_axi4_router_1x2.sv
// tb_axi4_router_1x2: directed scenario tests for the 1x2 AXI4 address router.
module tb_axi4_router_1x2;
  logic clk_i = 1'b0, rst_n = 1'b1;
  logic [3:0] in_awid, s0_awid, s1_awid, in_arid, s0_arid, s1_arid, in_bid, s0_bid, s1_bid, in_rid, s0_rid, s1_rid;
  logic [31:0] in_awaddr, s0_awaddr, s1_awaddr, in_araddr, s0_araddr, s1_araddr, in_wdata, s0_wdata, s1_wdata, in_rdata, s0_rdata, s1_rdata;
  logic [7:0] in_awlen, s0_awlen, s1_awlen, in_arlen, s0_arlen, s1_arlen;
  logic [2:0] in_awsize, s0_awsize, s1_awsize, in_arsize, s0_arsize, s1_arsize, in_awprot, s0_awprot, s1_awprot, in_arprot, s0_arprot, s1_arprot;
  logic [1:0] in_awburst, s0_awburst, s1_awburst, in_arburst, s0_arburst, s1_arburst, in_bresp, s0_bresp, s1_bresp, in_rresp, s0_rresp, s1_rresp;
  logic in_awlock, s0_awlock, s1_awlock, in_arlock, s0_arlock, s1_arlock;
  logic [3:0] in_awcache, s0_awcache, s1_awcache, in_arcache, s0_arcache, s1_arcache, in_awqos, s0_awqos, s1_awqos, in_arqos, s0_arqos, s1_arqos;
  logic [3:0] in_awregion, s0_awregion, s1_awregion, in_arregion, s0_arregion, s1_arregion, in_wstrb, s0_wstrb, s1_wstrb;
  logic in_wlast, s0_wlast, s1_wlast, in_rlast, s0_rlast, s1_rlast;
  logic in_awvalid, in_awready, s0_awvalid, s0_awready, s1_awvalid, s1_awready;
  logic in_wvalid, in_wready, s0_wvalid, s0_wready, s1_wvalid, s1_wready;
  logic in_bvalid, in_bready, s0_bvalid, s0_bready, s1_bvalid, s1_bready;
  logic in_arvalid, in_arready, s0_arvalid, s0_arready, s1_arvalid, s1_arready;
  logic in_rvalid, in_rready, s0_rvalid, s0_rready, s1_rvalid, s1_rready;
  logic [14:0] hs;
  int n_chk = 0, n_fail = 0;
  assign hs = {in_awready, in_wready, in_arready, in_bvalid, in_rvalid, s0_awvalid, s1_awvalid, s0_wvalid, s1_wvalid,
               s0_arvalid, s1_arvalid, s0_bready, s1_bready, s0_rready, s1_rready};
  axi4_router_1x2 dut (
    .clk_i, .rst_n,
    .in_awid, .in_awaddr, .in_awlen, .in_awsize, .in_awburst, .in_awlock, .in_awcache, .in_awprot, .in_awqos, .in_awregion, .in_awvalid, .in_awready,
    .in_wdata, .in_wstrb, .in_wlast, .in_wvalid, .in_wready, .in_bid, .in_bresp, .in_bvalid, .in_bready,
    .in_arid, .in_araddr, .in_arlen, .in_arsize, .in_arburst, .in_arlock, .in_arcache, .in_arprot, .in_arqos, .in_arregion, .in_arvalid, .in_arready,
    .in_rid, .in_rdata, .in_rresp, .in_rlast, .in_rvalid, .in_rready,
    .s0_awid, .s0_awaddr, .s0_awlen, .s0_awsize, .s0_awburst, .s0_awlock, .s0_awcache, .s0_awprot, .s0_awqos, .s0_awregion, .s0_awvalid, .s0_awready,
    .s0_wdata, .s0_wstrb, .s0_wlast, .s0_wvalid, .s0_wready, .s0_bid, .s0_bresp, .s0_bvalid, .s0_bready,
    .s0_arid, .s0_araddr, .s0_arlen, .s0_arsize, .s0_arburst, .s0_arlock, .s0_arcache, .s0_arprot, .s0_arqos, .s0_arregion, .s0_arvalid, .s0_arready,
    .s0_rid, .s0_rdata, .s0_rresp, .s0_rlast, .s0_rvalid, .s0_rready,
    .s1_awid, .s1_awaddr, .s1_awlen, .s1_awsize, .s1_awburst, .s1_awlock, .s1_awcache, .s1_awprot, .s1_awqos, .s1_awregion, .s1_awvalid, .s1_awready,
    .s1_wdata, .s1_wstrb, .s1_wlast, .s1_wvalid, .s1_wready, .s1_bid, .s1_bresp, .s1_bvalid, .s1_bready,
    .s1_arid, .s1_araddr, .s1_arlen, .s1_arsize, .s1_arburst, .s1_arlock, .s1_arcache, .s1_arprot, .s1_arqos, .s1_arregion, .s1_arvalid, .s1_arready,
    .s1_rid, .s1_rdata, .s1_rresp, .s1_rlast, .s1_rvalid, .s1_rready
  );
  always #5 clk_i = ~clk_i;
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask
  task automatic idle;
    {in_awid, in_awaddr, in_awlen, in_awsize, in_awburst, in_awlock, in_awcache, in_awprot, in_awqos, in_awregion, in_awvalid} = '0;
    {in_arid, in_araddr, in_arlen, in_arsize, in_arburst, in_arlock, in_arcache, in_arprot, in_arqos, in_arregion, in_arvalid} = '0;
    {in_wdata, in_wstrb, in_wlast, in_wvalid, in_bready, in_rready} = '0;
    {s0_awready, s0_wready, s0_bid, s0_bresp, s0_bvalid, s0_arready, s0_rid, s0_rdata, s0_rresp, s0_rlast, s0_rvalid} = '0;
    {s1_awready, s1_wready, s1_bid, s1_bresp, s1_bvalid, s1_arready, s1_rid, s1_rdata, s1_rresp, s1_rlast, s1_rvalid} = '0;
  endtask
  task automatic drive_aw(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
    in_awaddr = a; in_awid = id; in_awlen = len; in_awsize = 3'd2; in_awburst = 2'b01; in_awvalid = 1'b1;
  endtask
  task automatic drive_ar(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
    in_araddr = a; in_arid = id; in_arlen = len; in_arsize = 3'd2; in_arburst = 2'b01; in_arvalid = 1'b1;
  endtask
  task automatic test_reset;
    idle();
    #2 rst_n = 1'b0;
    {in_awvalid, in_arvalid, in_wvalid, in_bready, in_rready} = '1;
    {s0_awready, s0_wready, s0_bvalid, s0_arready, s0_rvalid, s1_awready, s1_wready, s1_bvalid, s1_arready, s1_rvalid} = '1;
    #1;
    n_chk++; if (hs !== 15'h0) begin n_fail++; $display("FAIL reset_handshakes got %h exp 0000", hs); end
    n_chk++; if (dut.wr_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_wr_cnt got %0d exp 0", dut.wr_cnt); end
    n_chk++; if (dut.rd_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_rd_cnt got %0d exp 0", dut.rd_cnt); end
    tick();
    idle();
    @(negedge clk_i) rst_n = 1'b1;
    tick();
  endtask
  task automatic test_write_s0;
    s0_awready = 1'b1; s1_awready = 1'b1;
    drive_aw(32'h0000_1000, 4'd5, 8'd3);
    #1;
    n_chk++; if ({s0_awvalid, s1_awvalid} !== 2'b10) begin n_fail++; $display("FAIL wr_aw_route got %b exp 10", {s0_awvalid, s1_awvalid}); end
    n_chk++; if (in_awready !== 1'b1) begin n_fail++; $display("FAIL wr_awready got %b exp 1", in_awready); end
    n_chk++; if (s1_awaddr !== 32'h0000_1000) begin n_fail++; $display("FAIL wr_aw_broadcast got %h exp 00001000", s1_awaddr); end
    tick();
    in_awvalid = 1'b0;
    n_chk++; if (dut.wr_cnt !== 3'd1) begin n_fail++; $display("FAIL wr_cnt_after_aw got %0d exp 1", dut.wr_cnt); end
    s0_wready = 1'b1; s1_wready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_wvalid = 1'b1; in_wdata = 32'hA0 + 32'(i); in_wlast = (i == 3);
      #1;
      n_chk++; if ({s0_wvalid, s1_wvalid} !== 2'b10) begin n_fail++; $display("FAIL wr_w_route beat %0d got %b exp 10", i, {s0_wvalid, s1_wvalid}); end
      n_chk++; if (s0_wlast !== (i == 3)) begin n_fail++; $display("FAIL wr_wlast beat %0d got %b exp %b", i, s0_wlast, i == 3); end
      n_chk++; if (in_wready !== 1'b1) begin n_fail++; $display("FAIL wr_wready beat %0d got %b exp 1", i, in_wready); end
      tick();
    end
    in_wlast = 1'b1;
    #1;
    n_chk++; if ({in_wready, s0_wvalid} !== 2'b00) begin n_fail++; $display("FAIL wr_w_without_aw got %b exp 00", {in_wready, s0_wvalid}); end
    in_wvalid = 1'b0;
    s0_bvalid = 1'b1; s0_bid = 4'd5; s0_bresp = 2'b00; in_bready = 1'b1;
    #1;
    n_chk++; if ({in_bvalid, in_bid, in_bresp} !== {1'b1, 4'd5, 2'b00}) begin n_fail++; $display("FAIL wr_b got v=%b id=%0d resp=%0d exp v=1 id=5 resp=0", in_bvalid, in_bid, in_bresp); end
    n_chk++; if ({s0_bready, s1_bready} !== 2'b10) begin n_fail++; $display("FAIL wr_bready got %b exp 10", {s0_bready, s1_bready}); end
    tick();
    s0_bvalid = 1'b0;
    n_chk++; if (dut.wr_cnt !== 3'd0) begin n_fail++; $display("FAIL wr_cnt_after_b got %0d exp 0", dut.wr_cnt); end
    idle();
  endtask
  task automatic test_read_s1;
    s0_arready = 1'b1; s1_arready = 1'b1;
    drive_ar(32'h2000_0000, 4'd9, 8'd7);
    #1;
    n_chk++; if ({s0_arvalid, s1_arvalid} !== 2'b01) begin n_fail++; $display("FAIL rd_ar_route got %b exp 01", {s0_arvalid, s1_arvalid}); end
    n_chk++; if (in_arready !== 1'b1) begin n_fail++; $display("FAIL rd_arready got %b exp 1", in_arready); end
    tick();
    in_arvalid = 1'b0;
    n_chk++; if (dut.rd_cnt !== 3'd1) begin n_fail++; $display("FAIL rd_cnt_after_ar got %0d exp 1", dut.rd_cnt); end
    in_rready = 1'b1; s0_rvalid = 1'b1; s0_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 8; i++) begin
      s1_rvalid = 1'b1; s1_rid = 4'd9; s1_rdata = 32'h100 + 32'(i); s1_rlast = (i == 7);
      #1;
      n_chk++; if ({in_rvalid, in_rid} !== {1'b1, 4'd9}) begin n_fail++; $display("FAIL rd_r beat %0d got v=%b id=%0d exp v=1 id=9", i, in_rvalid, in_rid); end
      n_chk++; if (in_rdata !== 32'h100 + 32'(i)) begin n_fail++; $display("FAIL rd_rdata beat %0d got %h exp %h", i, in_rdata, 32'h100 + 32'(i)); end
      n_chk++; if ({s0_rready, s1_rready} !== 2'b01) begin n_fail++; $display("FAIL rd_rready beat %0d got %b exp 01", i, {s0_rready, s1_rready}); end
      tick();
      if (i == 3) begin
        n_chk++; if (dut.rd_cnt !== 3'd1) begin n_fail++; $display("FAIL rd_cnt_mid_burst got %0d exp 1", dut.rd_cnt); end
      end
    end
    n_chk++; if (dut.rd_cnt !== 3'd0) begin n_fail++; $display("FAIL rd_cnt_after_rlast got %0d exp 0", dut.rd_cnt); end
    n_chk++; if (in_rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_stray_rvalid got %b exp 0", in_rvalid); end
    idle();
  endtask
  task automatic test_aw_switch_stall;
    s0_awready = 1'b1; s1_awready = 1'b1; s0_wready = 1'b1; s1_wready = 1'b1;
    drive_aw(32'h0000_0100, 4'd1, 8'd0);
    tick();
    drive_aw(32'h1000_0000, 4'd2, 8'd0);
    #1;
    n_chk++; if ({in_awready, s0_awvalid, s1_awvalid} !== 3'b000) begin n_fail++; $display("FAIL sw_aw_stall got %b exp 000", {in_awready, s0_awvalid, s1_awvalid}); end
    in_wvalid = 1'b1; in_wlast = 1'b1;
    #1;
    n_chk++; if ({s0_wvalid, s1_wvalid} !== 2'b10) begin n_fail++; $display("FAIL sw_w_s0 got %b exp 10", {s0_wvalid, s1_wvalid}); end
    tick();
    in_wvalid = 1'b0;
    s0_bvalid = 1'b1; s0_bid = 4'd1; in_bready = 1'b1;
    #1;
    n_chk++; if ({in_bvalid, in_awready} !== 2'b10) begin n_fail++; $display("FAIL sw_b_cycle got bvalid,awready=%b exp 10", {in_bvalid, in_awready}); end
    tick();
    s0_bvalid = 1'b0;
    #1;
    n_chk++; if ({in_awready, s1_awvalid} !== 2'b11) begin n_fail++; $display("FAIL sw_aw_s1_accept got %b exp 11", {in_awready, s1_awvalid}); end
    tick();
    in_awvalid = 1'b0;
    in_wvalid = 1'b1;
    #1;
    n_chk++; if ({s0_wvalid, s1_wvalid} !== 2'b01) begin n_fail++; $display("FAIL sw_w_s1 got %b exp 01", {s0_wvalid, s1_wvalid}); end
    tick();
    in_wvalid = 1'b0;
    s1_bvalid = 1'b1; s1_bid = 4'd2; s0_bvalid = 1'b1; s0_bid = 4'd7;
    #1;
    n_chk++; if (in_bid !== 4'd2) begin n_fail++; $display("FAIL sw_bid got %0d exp 2", in_bid); end
    n_chk++; if ({s0_bready, s1_bready} !== 2'b01) begin n_fail++; $display("FAIL sw_bready got %b exp 01", {s0_bready, s1_bready}); end
    tick();
    s1_bvalid = 1'b0;
    #1;
    n_chk++; if ({in_bvalid, s0_bready} !== 2'b00) begin n_fail++; $display("FAIL sw_stray_b got %b exp 00", {in_bvalid, s0_bready}); end
    idle();
  endtask
  task automatic test_max_outstanding;
    s0_awready = 1'b1; s0_wready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_aw(32'h40 * 32'(i), 4'(i), 8'd0);
      #1;
      n_chk++; if (in_awready !== 1'b1) begin n_fail++; $display("FAIL mx_aw%0d got %b exp 1", i, in_awready); end
      tick();
    end
    drive_aw(32'h400, 4'd4, 8'd0);
    #1;
    n_chk++; if ({in_awready, s0_awvalid} !== 2'b00) begin n_fail++; $display("FAIL mx_aw5_stall got %b exp 00", {in_awready, s0_awvalid}); end
    n_chk++; if (dut.wr_cnt !== 3'd4) begin n_fail++; $display("FAIL mx_cnt_full got %0d exp 4", dut.wr_cnt); end
    for (int j = 0; j < 2; j++) begin
      in_wvalid = 1'b1; in_wdata = 32'(j); in_wlast = (j == 1);
      #1;
      n_chk++; if (s0_wvalid !== 1'b1) begin n_fail++; $display("FAIL mx_w1 beat %0d got %b exp 1", j, s0_wvalid); end
      tick();
    end
    in_wvalid = 1'b0;
    s0_bvalid = 1'b1; in_bready = 1'b1;
    #1;
    n_chk++; if (in_awready !== 1'b0) begin n_fail++; $display("FAIL mx_aw5_during_b got %b exp 0", in_awready); end
    tick();
    s0_bvalid = 1'b0;
    #1;
    n_chk++; if (in_awready !== 1'b1) begin n_fail++; $display("FAIL mx_aw5_accept got %b exp 1", in_awready); end
    tick();
    in_awvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_wvalid = 1'b1; in_wlast = 1'b1; in_wdata = 32'h50 + 32'(k);
      #1;
      n_chk++; if ({s0_wvalid, s1_wvalid, in_wready} !== 3'b101) begin n_fail++; $display("FAIL mx_drain_w%0d got %b exp 101", k, {s0_wvalid, s1_wvalid, in_wready}); end
      tick();
    end
    #1;
    n_chk++; if (in_wready !== 1'b0) begin n_fail++; $display("FAIL mx_fifo_empty got %b exp 0", in_wready); end
    in_wvalid = 1'b0;
    s0_bvalid = 1'b1;
    repeat (4) tick();
    n_chk++; if ({dut.wr_cnt, in_bvalid} !== {3'd0, 1'b0}) begin n_fail++; $display("FAIL mx_drain_b got cnt=%0d bvalid=%b exp cnt=0 bvalid=0", dut.wr_cnt, in_bvalid); end
    idle();
  endtask
  task automatic test_boundary_concurrent;
    logic [31:0] addr_tab [4] = '{32'h0FFF_FFFF, 32'h1000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    logic [1:0] route_tab [4] = '{2'b10, 2'b01, 2'b01, 2'b10};
    for (int i = 0; i < 4; i++) begin
      drive_ar(addr_tab[i], 4'd0, 8'd0);
      #1;
      n_chk++; if ({s0_arvalid, s1_arvalid} !== route_tab[i]) begin n_fail++; $display("FAIL bd_decode %h got %b exp %b", addr_tab[i], {s0_arvalid, s1_arvalid}, route_tab[i]); end
    end
    {s0_arready, s1_arready, s0_awready, s1_awready, s0_wready, s1_wready, in_rready, in_bready} = '1;
    drive_ar(32'h0FFF_FFFC, 4'd3, 8'd0);
    drive_aw(32'h3000_0000, 4'd4, 8'd0);
    #1;
    n_chk++; if ({s0_arvalid, s1_arvalid, s0_awvalid, s1_awvalid} !== 4'b1001) begin n_fail++; $display("FAIL bd_conc_route got %b exp 1001", {s0_arvalid, s1_arvalid, s0_awvalid, s1_awvalid}); end
    n_chk++; if ({in_arready, in_awready} !== 2'b11) begin n_fail++; $display("FAIL bd_conc_ready got %b exp 11", {in_arready, in_awready}); end
    tick();
    {in_arvalid, in_awvalid} = '0;
    in_wvalid = 1'b1; in_wlast = 1'b1;
    s0_rvalid = 1'b1; s0_rlast = 1'b1; s0_rid = 4'd3;
    #1;
    n_chk++; if ({s1_wvalid, in_rvalid, in_rid} !== {2'b11, 4'd3}) begin n_fail++; $display("FAIL bd_conc_data got w=%b r=%b rid=%0d exp w=1 r=1 rid=3", s1_wvalid, in_rvalid, in_rid); end
    tick();
    {in_wvalid, s0_rvalid} = '0;
    s1_bvalid = 1'b1; s1_bid = 4'd4;
    drive_ar(32'h1000_0000, 4'd6, 8'd0);
    #1;
    n_chk++; if ({in_bvalid, in_bid} !== {1'b1, 4'd4}) begin n_fail++; $display("FAIL bd_b_s1 got v=%b id=%0d exp v=1 id=4", in_bvalid, in_bid); end
    n_chk++; if ({s0_arvalid, s1_arvalid, in_arready} !== 3'b011) begin n_fail++; $display("FAIL bd_ar_s1 got %b exp 011", {s0_arvalid, s1_arvalid, in_arready}); end
    tick();
    {s1_bvalid, in_arvalid} = '0;
    s1_rvalid = 1'b1; s1_rlast = 1'b1; s1_rid = 4'd6;
    #1;
    n_chk++; if ({in_rvalid, in_rid} !== {1'b1, 4'd6}) begin n_fail++; $display("FAIL bd_r_s1 got v=%b id=%0d exp v=1 id=6", in_rvalid, in_rid); end
    tick();
    n_chk++; if ({dut.rd_cnt, dut.wr_cnt} !== 6'd0) begin n_fail++; $display("FAIL bd_counts got rd=%0d wr=%0d exp 0 0", dut.rd_cnt, dut.wr_cnt); end
    idle();
  endtask
  task automatic test_reset_mid_burst;
    s0_awready = 1'b1; s0_wready = 1'b1;
    drive_aw(32'h0000_0200, 4'd1, 8'd1);
    tick();
    in_awvalid = 1'b0;
    in_wvalid = 1'b1; in_wlast = 1'b0;
    tick();
    in_wlast = 1'b1;
    drive_aw(32'h0000_0300, 4'd2, 8'd0);
    drive_ar(32'h0000_0300, 4'd2, 8'd0);
    {in_bready, in_rready, s1_awready, s1_wready, s0_arready, s1_arready, s0_bvalid, s1_bvalid, s0_rvalid, s1_rvalid} = '1;
    #1;
    n_chk++; if (s0_wvalid !== 1'b1) begin n_fail++; $display("FAIL rm_pre_wvalid got %b exp 1", s0_wvalid); end
    rst_n = 1'b0;
    #1;
    n_chk++; if (hs !== 15'h0) begin n_fail++; $display("FAIL rm_async_handshakes got %h exp 0000", hs); end
    n_chk++; if ({dut.wr_cnt, dut.rd_cnt} !== 6'd0) begin n_fail++; $display("FAIL rm_async_counts got wr=%0d rd=%0d exp 0 0", dut.wr_cnt, dut.rd_cnt); end
    idle();
    #1 rst_n = 1'b1;
    s1_awready = 1'b1; s1_wready = 1'b1; in_wvalid = 1'b1; in_wlast = 1'b1;
    drive_aw(32'h1000_0000, 4'd8, 8'd0);
    #1;
    n_chk++; if ({in_awready, s1_awvalid, in_wready} !== 3'b110) begin n_fail++; $display("FAIL rm_post_aw got %b exp 110", {in_awready, s1_awvalid, in_wready}); end
    tick();
    n_chk++; if ({dut.wr_cnt, dut.wr_tgt} !== {3'd1, 1'b1}) begin n_fail++; $display("FAIL rm_post_state got cnt=%0d tgt=%b exp cnt=1 tgt=1", dut.wr_cnt, dut.wr_tgt); end
    idle();
  endtask
  initial begin
    test_reset();
    test_write_s0();
    test_read_s1();
    test_aw_switch_stall();
    test_max_outstanding();
    test_boundary_concurrent();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
